orv64_icache_refill_resp: RTL and testbench

//  Memory-side responder for ICache line misses. Accepts one miss request, issues a line-aligned read to the

---
 rtl/orv64_param_pkg.sv | 22 ++
 rtl/orv64_refill_line_buf.sv | 59 +++++
 rtl/orv64_icache_refill_resp.sv | 180 ++++++++++++++++++
 tb/tb_orv64_icache_refill_resp.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orv64_param_pkg.sv
`default_nettype none
// ============================================================================
// Package     : orv64_param_pkg
// Description : Shared ORV64 widths and ICache refill state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package orv64_param_pkg;

  localparam int ORV64_PHY_ADDR_WIDTH      = 56;
  localparam int ORV64_ICACHE_LINE_WIDTH   = 256;
  localparam int ORV64_ICACHE_REFILL_BEATS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FILL  = 3'd4
  } orv64_refill_state_e;

endpackage
`default_nettype wire

// File: rtl/orv64_refill_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : orv64_refill_line_buf
// Description : Beat-indexed line register with a sticky error bit. A clear
//               zeroes the line and the error before a new refill begins.
// Revision    : 1.0 - initial release
// ============================================================================
module orv64_refill_line_buf #(
  parameter int LINE_W  = 256,
  parameter int BEAT_W  = 64,
  parameter int N_BEATS = LINE_W / BEAT_W,
  parameter int IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              wr_err,
  output logic [LINE_W-1:0] line,
  output logic              err
);

  logic [LINE_W-1:0] r_line;
  logic              r_err;

  // One register slice per beat; only the slice addressed by wr_idx updates.
  generate
    for (genvar k = 0; k < N_BEATS; k++) begin : g_beat
      // Beat k slice: cleared on a new refill, written when its index is hit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_line[k*BEAT_W +: BEAT_W] <= '0;
        end else if (clr) begin
          r_line[k*BEAT_W +: BEAT_W] <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(k))) begin
          r_line[k*BEAT_W +: BEAT_W] <= wr_data;
        end
      end
    end
  endgenerate

  // Sticky error: any erroneous beat in the burst marks the whole line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (clr) begin
      r_err <= 1'b0;
    end else if (wr_en) begin
      r_err <= r_err | wr_err;
    end
  end

  assign line = r_line;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: rtl/orv64_icache_refill_resp.sv
`default_nettype none
// ============================================================================
// Module      : orv64_icache_refill_resp
// Description : ICache miss responder. Accepts one miss, issues a line-aligned
//               memory read, gathers the return beats into a line and hands
//               the full line back to the ICache refill path.
// Options     : ORV64_ICACHE_CRIT_WORD_FIRST_EN adds the crit_valid/crit_data
//               early critical-word output.
// Revision    : 1.0 - initial release
// ============================================================================
module orv64_icache_refill_resp
  import orv64_param_pkg::*;
#(
  parameter int PADDR_W = ORV64_PHY_ADDR_WIDTH,
  parameter int LINE_W  = ORV64_ICACHE_LINE_WIDTH,
  parameter int BEAT_W  = 64,
  parameter int N_BEATS = LINE_W / BEAT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               miss_req_valid,
  output logic               miss_req_ready,
  input  logic [PADDR_W-1:0] miss_req_paddr,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [PADDR_W-1:0] mem_req_paddr,
  input  logic               mem_resp_valid,
  output logic               mem_resp_ready,
  input  logic [BEAT_W-1:0]  mem_resp_data,
  input  logic               mem_resp_err,
  output logic               fill_valid,
  input  logic               fill_ready,
  output logic [PADDR_W-1:0] fill_paddr,
  output logic [LINE_W-1:0]  fill_data,
  output logic               fill_err
`ifdef ORV64_ICACHE_CRIT_WORD_FIRST_EN
  ,
  output logic               crit_valid,
  output logic [31:0]        crit_data
`endif
);

  localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]   C_LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [PADDR_W-1:0] C_OFF_MASK  = PADDR_W'((LINE_W / 8) - 1);

  orv64_refill_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
  logic [PADDR_W-1:0]  r_paddr;
  logic                w_capture;
  logic                w_beat_wr;
  logic                w_beat_last;

  // State and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  // Next-state, counter and handshake outputs; flush outranks every event.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    miss_req_ready = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    fill_valid     = 1'b0;
    w_capture      = 1'b0;
    w_beat_wr      = 1'b0;
    w_beat_last    = (r_beat_cnt == C_LAST_BEAT);
    unique case (r_state)
      ST_IDLE: begin
        miss_req_ready = !flush;
        if (miss_req_valid && !flush) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        // A request accepted in the flush cycle is still outstanding, so its
        // beats must be drained rather than abandoned.
        if (mem_req_ready) begin
          w_beat_cnt_nxt = '0;
          w_state_nxt    = flush ? ST_DRAIN : ST_WAIT;
        end else if (flush) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        mem_resp_ready = 1'b1;
        w_beat_wr      = mem_resp_valid;
        if (mem_resp_valid) begin
          w_beat_cnt_nxt = w_beat_last ? '0 : r_beat_cnt + CNT_W'(1);
        end
        if (mem_resp_valid && w_beat_last) begin
          w_state_nxt = flush ? ST_IDLE : ST_FILL;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          w_beat_cnt_nxt = w_beat_last ? '0 : r_beat_cnt + CNT_W'(1);
          if (w_beat_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_FILL: begin
        // Masking valid during flush keeps a dropped line from handshaking.
        fill_valid = !flush;
        if (flush || fill_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Line-aligned miss address, captured on the miss handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_paddr <= '0;
    end else if (w_capture) begin
      r_paddr <= miss_req_paddr & ~C_OFF_MASK;
    end
  end

  orv64_refill_line_buf #(
    .LINE_W  (LINE_W),
    .BEAT_W  (BEAT_W),
    .N_BEATS (N_BEATS),
    .IDX_W   (CNT_W)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_capture),
    .wr_en   (w_beat_wr),
    .wr_idx  (r_beat_cnt),
    .wr_data (mem_resp_data),
    .wr_err  (mem_resp_err),
    .line    (fill_data),
    .err     (fill_err)
  );

  assign mem_req_paddr = r_paddr;
  assign fill_paddr    = r_paddr;

`ifdef ORV64_ICACHE_CRIT_WORD_FIRST_EN
  // Word offset of the missing instruction within the line.
  logic [OFF_W-3:0] r_crit_off;

  // Critical word offset, captured alongside the line address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crit_off <= '0;
    end else if (w_capture) begin
      r_crit_off <= miss_req_paddr[OFF_W-1:2];
    end
  end

  // Upper offset bits select the beat, the lowest bit picks the 32-bit half.
  assign crit_valid = (r_state == ST_WAIT) && mem_resp_valid && !mem_resp_err && !flush &&
                      (r_beat_cnt == r_crit_off[OFF_W-3:1]);
  assign crit_data  = r_crit_off[0] ? mem_resp_data[63:32] : mem_resp_data[31:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_orv64_icache_refill_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_orv64_icache_refill_resp
// Description : Directed/randomized self-checking bench for the ICache refill
//               responder, with an address/line model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_orv64_icache_refill_resp;

  localparam int PW = 56;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          miss_req_valid = 1'b0;
  logic          miss_req_ready;
  logic [PW-1:0] miss_req_paddr = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [PW-1:0] mem_req_paddr;
  logic          mem_resp_valid = 1'b0;
  logic          mem_resp_ready;
  logic [63:0]   mem_resp_data = '0;
  logic          mem_resp_err = 1'b0;
  logic          fill_valid;
  logic          fill_ready = 1'b0;
  logic [PW-1:0] fill_paddr;
  logic [255:0]  fill_data;
  logic          fill_err;
`ifdef ORV64_ICACHE_CRIT_WORD_FIRST_EN
  logic          crit_valid;
  logic [31:0]   crit_data;
`endif

  int total = 0;
  int bad   = 0;
  int n_memreq = 0;
  int n_fill   = 0;

  orv64_icache_refill_resp dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .miss_req_valid (miss_req_valid),
    .miss_req_ready (miss_req_ready),
    .miss_req_paddr (miss_req_paddr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_paddr  (mem_req_paddr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .fill_valid     (fill_valid),
    .fill_ready     (fill_ready),
    .fill_paddr     (fill_paddr),
    .fill_data      (fill_data),
    .fill_err       (fill_err)
`ifdef ORV64_ICACHE_CRIT_WORD_FIRST_EN
    ,
    .crit_valid     (crit_valid),
    .crit_data      (crit_data)
`endif
  );

  always #5 clk = ~clk;

  // Handshake counters observed at the active edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) n_memreq++;
      if (fill_valid && fill_ready) n_fill++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_crit_idle(input string tag);
`ifdef ORV64_ICACHE_CRIT_WORD_FIRST_EN
    chk({tag, ".crit_idle"}, crit_valid, 1'b0);
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".miss_rdy"},  miss_req_ready, 1'b1);
    chk({tag, ".mreq_v"},    mem_req_valid,  1'b0);
    chk({tag, ".mresp_rdy"}, mem_resp_ready, 1'b0);
    chk({tag, ".fill_v"},    fill_valid,     1'b0);
    chk({tag, ".fill_pa"},   fill_paddr,     '0);
    chk({tag, ".fill_d"},    fill_data,      '0);
    chk({tag, ".fill_e"},    fill_err,       1'b0);
    chk_crit_idle(tag);
  endtask

  // Full refill: miss, request with stalls, 4 beats with gaps, fill with stalls.
  task automatic do_refill(input string tag, input logic [PW-1:0] pa, input logic [255:0] line,
                           input logic [3:0] emask, input int req_stall, input int fill_stall);
    logic [PW-1:0] exp_pa;
    logic [63:0]   beat;
    logic          exp_cv;
    int            req0;
    int            fill0;
    exp_pa = pa & ~PW'(32'h1f);
    req0   = n_memreq;
    fill0  = n_fill;
    @(negedge clk);
    miss_req_valid = 1'b1;
    miss_req_paddr = pa;
    #1 chk({tag, ".miss_rdy"}, miss_req_ready, 1'b1);
    for (int i = 0; i <= req_stall; i++) begin
      @(negedge clk);
      miss_req_valid = 1'b0;
      miss_req_paddr = PW'({$urandom(), $urandom()});
      mem_req_ready  = (i == req_stall);
      #1;
      chk({tag, ".mreq_v"},  mem_req_valid, 1'b1);
      chk({tag, ".mreq_pa"}, mem_req_paddr, exp_pa);
      chk({tag, ".busy"},    miss_req_ready, 1'b0);
    end
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        chk({tag, ".gap_rdy"}, mem_resp_ready, 1'b1);
        chk({tag, ".gap_fv"},  fill_valid, 1'b0);
        chk_crit_idle(tag);
      end
      @(negedge clk);
      mem_req_ready  = 1'b0;
      beat           = line[64*b +: 64];
      mem_resp_valid = 1'b1;
      mem_resp_data  = beat;
      mem_resp_err   = emask[b];
      #1;
      chk({tag, ".beat_rdy"}, mem_resp_ready, 1'b1);
      exp_cv = (b == int'(pa[4:3])) && !emask[b];
`ifdef ORV64_ICACHE_CRIT_WORD_FIRST_EN
      chk({tag, ".crit_v"}, crit_valid, exp_cv);
      if (exp_cv) chk({tag, ".crit_d"}, crit_data, pa[2] ? beat[63:32] : beat[31:0]);
`endif
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    fill_ready     = (fill_stall == 0);
    #1;
    chk({tag, ".fill_v"},   fill_valid, 1'b1);
    chk({tag, ".fill_d"},   fill_data,  line);
    chk({tag, ".fill_pa"},  fill_paddr, exp_pa);
    chk({tag, ".fill_e"},   fill_err,   |emask);
    chk({tag, ".no_accept"}, miss_req_ready, 1'b0);
    chk({tag, ".no_mreq"},  mem_req_valid, 1'b0);
    for (int i = 1; i <= fill_stall; i++) begin
      @(negedge clk);
      fill_ready = (i == fill_stall);
      #1;
      chk({tag, ".hold_fv"}, fill_valid, 1'b1);
      chk({tag, ".hold_fd"}, fill_data,  line);
      chk({tag, ".hold_pa"}, fill_paddr, exp_pa);
      chk({tag, ".hold_mr"}, miss_req_ready, 1'b0);
    end
    @(negedge clk);
    fill_ready = 1'b0;
    #1;
    chk({tag, ".done_fv"}, fill_valid, 1'b0);
    chk({tag, ".done_mr"}, miss_req_ready, 1'b1);
    chk({tag, ".n_req"},   n_memreq - req0, 1);
    chk({tag, ".n_fill"},  n_fill - fill0, 1);
  endtask

  // Miss plus immediate request acceptance; leaves the DUT in the beat phase.
  task automatic start_miss(input logic [PW-1:0] pa);
    @(negedge clk);
    miss_req_valid = 1'b1;
    miss_req_paddr = pa;
    @(negedge clk);
    miss_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
  endtask

  task automatic send_beat(input string tag, input logic f);
    @(negedge clk);
    mem_req_ready  = 1'b0;
    flush          = f;
    mem_resp_valid = 1'b1;
    mem_resp_data  = {$urandom(), $urandom()};
    #1 chk({tag, ".beat_rdy"}, mem_resp_ready, 1'b1);
  endtask

  // Discarded beats after a flush, then confirm the return to idle.
  task automatic drain(input string tag, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      flush          = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom(), $urandom()};
      #1;
      chk({tag, ".drain_rdy"}, mem_resp_ready, 1'b1);
      chk({tag, ".drain_fv"},  fill_valid, 1'b0);
      chk_crit_idle(tag);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk({tag, ".idle_rdy"},  mem_resp_ready, 1'b0);
    chk({tag, ".idle_fv"},   fill_valid, 1'b0);
    chk({tag, ".idle_mr"},   miss_req_ready, 1'b1);
  endtask

  initial begin
    int req0;
    int fill0;
    // Reset state.
    @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic miss with fixed beats.
    do_refill("basic", 56'h80001234,
              {64'h4444444444444444, 64'h3333333333333333,
               64'h2222222222222222, 64'h1111111111111111}, 4'b0000, 0, 0);
    // Request and fill backpressure.
    do_refill("bp", PW'({$urandom(), $urandom()}),
              {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()}, 4'b0000, 5, 3);
    // Error on beat 2 only.
    do_refill("err", 56'h00ABCDEF0048,
              {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()}, 4'b0100, 0, 1);
    // Critical word at offset 7 (last word of the line).
    do_refill("crit", 56'h8000001C,
              {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()}, 4'b0000, 1, 0);
    // Randomized refills.
    for (int r = 0; r < 4; r++) begin
      do_refill("rand", PW'({$urandom(), $urandom()}),
                {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()},
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Flush in WAIT after beat 1: two more beats drained, no fill.
    fill0 = n_fill;
    start_miss(56'h12340);
    send_beat("fw", 1'b0);
    send_beat("fw", 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    flush          = 1'b1;
    #1 chk("fw.flush_fv", fill_valid, 1'b0);
    drain("fw", 2);
    chk("fw.no_fill", n_fill - fill0, 0);

    // Flush arriving together with beat 1: that beat counts, two remain.
    start_miss(56'h55540);
    send_beat("fwb", 1'b0);
    send_beat("fwb", 1'b1);
    drain("fwb", 2);
    chk("fwb.no_fill", n_fill - fill0, 0);

    // Flush in REQ while the request is stalled: no request issued.
    req0 = n_memreq;
    @(negedge clk);
    miss_req_valid = 1'b1;
    miss_req_paddr = 56'h777700;
    @(negedge clk);
    miss_req_valid = 1'b0;
    mem_req_ready  = 1'b0;
    flush          = 1'b1;
    #1 chk("freq0.mreq_v", mem_req_valid, 1'b1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("freq0.mreq_v_off", mem_req_valid, 1'b0);
    chk("freq0.idle_mr",    miss_req_ready, 1'b1);
    chk("freq0.n_req",      n_memreq - req0, 0);

    // Flush in REQ with the request accepted: all four beats drained.
    @(negedge clk);
    miss_req_valid = 1'b1;
    miss_req_paddr = 56'h888800;
    @(negedge clk);
    miss_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    flush          = 1'b1;
    drain("freq1", 4);
    chk("freq1.n_req",   n_memreq - req0, 1);
    chk("freq1.no_fill", n_fill - fill0, 0);

    // Back to normal operation after flushes.
    do_refill("post", 56'h9000_0004,
              {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()}, 4'b0001, 0, 0);

    // Asynchronous reset in the middle of the beat phase.
    start_miss(56'hBEEF_001C);
    send_beat("arst", 1'b0);
    send_beat("arst", 1'b0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("arst");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst.idle_mr", miss_req_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
